sawtooth_analyzer: RTL and testbench
====================================

Name: sawtooth_analyzer

Overview:
Receive-side counterpart of the team's phase-accumulator sawtooth generator. Consumes a stream of sawtooth samples and recovers the generator's step (the per-sample increment) and the wrap period in samples. Indicates lock and flags step discontinuities. Sits on the capture/loopback path and checks generator output in system and in test.

Parameters:
WIDTH, 16, sample and step width in bits.
PERIOD_W, 20, period counter width in bits.
LOCK_COUNT, 4, number of consecutive consistent differences required to declare lock; must be at least 2.
TOL, 1, maximum allowed absolute deviation, in LSBs, of a difference from the locked step.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
sample_valid  in  1  qualifies sample; gaps are allowed.
sample  in  WIDTH  unsigned sawtooth sample.
step_out  out  WIDTH  recovered step; holds its value until the next lock.
step_valid  out  1  one-cycle pulse when lock is first acquired.
locked  out  1  high while in LOCKED.
period_out  out  PERIOD_W  samples between the last two wraps.
period_valid  out  1  one-cycle pulse when period_out updates.
wrap_pulse  out  1  one-cycle pulse on each detected wrap.
err_pulse  out  1  one-cycle pulse on loss of lock.

Behaviour:
- Interface: reset is asynchronous and active-high; the clock is clk.
- Reset values: all outputs are 0; state is IDLE; prev, cand, consec and period counter are 0; first_wrap_seen is 0.
- All outputs are registered. Every response appears one cycle after the sample_valid cycle that caused it. Cycles where sample_valid is low change nothing except clearing the pulse outputs.
- Difference: diff = sample - prev, computed modulo 2^WIDTH. Because the subtraction is modular, diff equals the step even across a wrap.
- Deviation: dev = diff - cand, interpreted as signed WIDTH bits. A difference is consistent when |dev| <= TOL.
- Wrap detection: a wrap occurs when sample < prev (unsigned), and only in ACQ or LOCKED.
- State IDLE: on a valid sample, set prev = sample and go to ACQ. No diff is computed.
- State ACQ, per valid sample:
  - On the first diff after IDLE, or on an inconsistent diff: cand = diff, consec = 1.
  - On a consistent diff: consec increments.
  - When consec reaches LOCK_COUNT: go to LOCKED, step_out = cand, pulse step_valid, locked goes high.
- State LOCKED, per valid sample:
  - Consistent diff: no change; cand is not tracked.
  - Inconsistent diff: pulse err_pulse, locked goes low, go to ACQ with cand = diff and consec = 1.
- step = 0 (constant input) is legal. It locks with step_out = 0, and no wraps occur.
- Period counter:
  - On a wrap: if first_wrap_seen is set, period_out = counter and period_valid pulses. Then the counter loads 1 and first_wrap_seen is set.
  - On a non-wrap valid sample: the counter increments, saturating at 2^PERIOD_W - 1.
  - A saturated value is still reported at the next wrap.
- Wrap and lock events in the same cycle are both reported.
- Reset mid-operation returns to IDLE immediately. After reset, the first wrap only restarts the period count and produces no period_valid.
- Lock state does not gate period reporting.

Optional Feature:
SAW_ANALYZER_PEAK_EN
- Defined: adds outputs peak_out[WIDTH] and trough_out[WIDTH].
  - Running max and min are tracked over the valid samples of the current period.
  - On a wrap with first_wrap_seen set, peak_out and trough_out are loaded alongside period_out.
  - The trackers then restart from the wrap sample.
  - Reset value of peak_out and trough_out is 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package saw_pkg holds:
  - the state enum {IDLE, ACQ, LOCKED};
  - default constants SAW_WIDTH = 16 and SAW_PERIOD_W = 20;
  - the function that computes the modular signed deviation.
- One natural sub-module, saw_period_counter: wrap detect, saturating counter, first-wrap flag, and (under the macro) peak/trough tracking.
- The top level holds the lock FSM.

Test Plan:
- Continuous ramp: step 0x0100 from 0x0000 -> step_valid and locked one cycle after the 5th sample (0x0400); step_out = 0x0100; after the second wrap, period_out = 256.
- Non-integer period: step 0x3000 -> lock with step_out = 0x3000; every period_out is 5 or 6; wrap_pulse follows the sample 0x2000 that follows 0xF000.
- Step change while locked: 0x0100 changes to 0x0200 -> err_pulse once, locked = 0, relock after 4 new diffs with step_out = 0x0200.
- Tolerance: TOL = 1, diffs 0x0100, 0x0101, 0x00FF, 0x0100 -> lock with step_out = 0x0100. A later diff of 0x0102 -> err_pulse.
- Gaps and reset: random sample_valid gaps -> same results as the gap-free run. Reset asserted while locked -> all outputs 0 next edge; the first wrap after reset gives no period_valid.
- Saturation and zero step: PERIOD_W = 4 with step 0x0100 -> period_out = 15. Constant input 0x1234 -> lock with step_out = 0, no wrap_pulse.

Source files
------------

// File: rtl/saw_pkg.sv
// Shared types, default widths and the deviation helper for the sawtooth analyzer.
// Optional peak/trough reporting is enabled with SAW_ANALYZER_PEAK_EN.
package saw_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} saw_state_t;

    localparam int SAW_WIDTH    = 16;
    localparam int SAW_PERIOD_W = 20;

    // (diff - cand) taken modulo 2^width, then sign-extended so callers compare against +/-TOL.
    function automatic logic signed [31:0] saw_deviation(input logic [31:0] diff,
                                                         input logic [31:0] cand,
                                                         input int          width);
        logic [31:0] raw;
        raw = diff - cand;
        return $signed(raw << (32 - width)) >>> (32 - width);
    endfunction

endpackage

// File: rtl/saw_period_counter.sv
// Wrap detection, saturating samples-per-period counter and first-wrap tracking.
// Peak/trough capture per period exists only when SAW_ANALYZER_PEAK_EN is defined.
module saw_period_counter
    import saw_pkg::*;
#(
    parameter int WIDTH    = SAW_WIDTH,
    parameter int PERIOD_W = SAW_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic                active,
    input  logic [WIDTH-1:0]    sample,
    input  logic [WIDTH-1:0]    prev,
    output logic                wrap_pulse,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid
`ifdef SAW_ANALYZER_PEAK_EN
    ,
    output logic [WIDTH-1:0]    peak_out,
    output logic [WIDTH-1:0]    trough_out
`endif
);

    localparam logic [PERIOD_W-1:0] COUNT_MAX = '1;

    logic                wrap;
    logic [PERIOD_W-1:0] count;
    logic                first_wrap_seen;

    assign wrap = sample_valid && active && (sample < prev);

    // The first wrap after reset only restarts the count; a period is known from the second on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_pulse      <= 1'b0;
            period_out      <= '0;
            period_valid    <= 1'b0;
            count           <= '0;
            first_wrap_seen <= 1'b0;
        end else begin
            wrap_pulse   <= wrap;
            period_valid <= 1'b0;
            if (wrap) begin
                if (first_wrap_seen) begin
                    period_out   <= count;
                    period_valid <= 1'b1;
                end
                count           <= PERIOD_W'(1);
                first_wrap_seen <= 1'b1;
            end else if (sample_valid && count != COUNT_MAX) begin
                count <= count + PERIOD_W'(1);
            end
        end
    end

`ifdef SAW_ANALYZER_PEAK_EN
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_min;

    // Extremes of the closing period are published on a wrap; the wrap sample opens the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max    <= '0;
            run_min    <= '0;
            peak_out   <= '0;
            trough_out <= '0;
        end else if (wrap) begin
            if (first_wrap_seen) begin
                peak_out   <= run_max;
                trough_out <= run_min;
            end
            run_max <= sample;
            run_min <= sample;
        end else if (sample_valid) begin
            if (sample > run_max) run_max <= sample;
            if (sample < run_min) run_min <= sample;
        end
    end
`endif

endmodule

// File: rtl/sawtooth_analyzer.sv
// Recovers step and wrap period from a sawtooth sample stream and tracks lock.
// Define SAW_ANALYZER_PEAK_EN to add peak_out/trough_out per-period extremes.
module sawtooth_analyzer
    import saw_pkg::*;
#(
    parameter int WIDTH      = SAW_WIDTH,
    parameter int PERIOD_W   = SAW_PERIOD_W,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [WIDTH-1:0]    sample,
    output logic [WIDTH-1:0]    step_out,
    output logic                step_valid,
    output logic                locked,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                wrap_pulse,
    output logic                err_pulse
`ifdef SAW_ANALYZER_PEAK_EN
    ,
    output logic [WIDTH-1:0]    peak_out,
    output logic [WIDTH-1:0]    trough_out
`endif
);

    localparam int CW = $clog2(LOCK_COUNT + 1);

    saw_state_t        state, state_next;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  cand, cand_next;
    logic [WIDTH-1:0]  step_next;
    logic [WIDTH-1:0]  diff;
    logic [CW-1:0]     consec, consec_next;
    logic              step_valid_next;
    logic              err_next;
    logic              consistent;
    logic signed [31:0] dev;

    // Modular subtraction keeps diff equal to the step even across a wrap.
    assign diff       = sample - prev;
    assign dev        = saw_deviation(32'(diff), 32'(cand), WIDTH);
    assign consistent = (dev >= -TOL) && (dev <= TOL);

    // consec == 0 marks the first diff after IDLE, which always seeds the candidate.
    always_comb begin
        state_next      = state;
        cand_next       = cand;
        consec_next     = consec;
        step_next       = step_out;
        step_valid_next = 1'b0;
        err_next        = 1'b0;
        if (sample_valid) begin
            case (state)
                IDLE: state_next = ACQ;
                ACQ: begin
                    if (consec == '0 || !consistent) begin
                        cand_next   = diff;
                        consec_next = CW'(1);
                    end else begin
                        consec_next = consec + CW'(1);
                        if (consec_next == CW'(LOCK_COUNT)) begin
                            state_next      = LOCKED;
                            step_next       = cand;
                            step_valid_next = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!consistent) begin
                        err_next    = 1'b1;
                        state_next  = ACQ;
                        cand_next   = diff;
                        consec_next = CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            cand       <= '0;
            consec     <= '0;
            step_out   <= '0;
            step_valid <= 1'b0;
            err_pulse  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_next;
            cand       <= cand_next;
            consec     <= consec_next;
            step_out   <= step_next;
            step_valid <= step_valid_next;
            err_pulse  <= err_next;
            locked     <= (state_next == LOCKED);
            if (sample_valid) prev <= sample;
        end
    end

    saw_period_counter #(
        .WIDTH    (WIDTH),
        .PERIOD_W (PERIOD_W)
    ) u_period (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .active       (state != IDLE),
        .sample       (sample),
        .prev         (prev),
        .wrap_pulse   (wrap_pulse),
        .period_out   (period_out),
        .period_valid (period_valid)
`ifdef SAW_ANALYZER_PEAK_EN
        ,
        .peak_out     (peak_out),
        .trough_out   (trough_out)
`endif
    );

endmodule

// File: tb/tb_sawtooth_analyzer.sv
// Scoreboard bench for sawtooth_analyzer: directed sample streams push expected events,
// a negedge monitor pops and compares them; a PERIOD_W=4 copy checks saturation.
module tb_sawtooth_analyzer;

    localparam int W  = 16;
    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [W-1:0]  sample;
    logic [W-1:0]  step_out;
    logic          step_valid;
    logic          locked;
    logic [PW-1:0] period_out;
    logic          period_valid;
    logic          wrap_pulse;
    logic          err_pulse;

    logic [W-1:0]  sat_step_out;
    logic          sat_step_valid;
    logic          sat_locked;
    logic [3:0]    sat_period_out;
    logic          sat_period_valid;
    logic          sat_wrap_pulse;
    logic          sat_err_pulse;

    sawtooth_analyzer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .step_out     (step_out),
        .step_valid   (step_valid),
        .locked       (locked),
        .period_out   (period_out),
        .period_valid (period_valid),
        .wrap_pulse   (wrap_pulse),
        .err_pulse    (err_pulse)
    );

    sawtooth_analyzer #(.PERIOD_W(4)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .step_out     (sat_step_out),
        .step_valid   (sat_step_valid),
        .locked       (sat_locked),
        .period_out   (sat_period_out),
        .period_valid (sat_period_valid),
        .wrap_pulse   (sat_wrap_pulse),
        .err_pulse    (sat_err_pulse)
    );

    always #5 clk = ~clk;

    typedef enum {EV_WRAP, EV_PERIOD, EV_STEP, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       value;
        int       at_sample;
    } ev_t;

    ev_t          exp_q[$];
    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [W-1:0] resp_sample  = '0;
    bit           use_gaps     = 1'b0;

    function automatic void expectEvent(ev_kind_t k, int v, int s);
        ev_t e;
        e.kind      = k;
        e.value     = v;
        e.at_sample = s;
        exp_q.push_back(e);
    endfunction

    function automatic void checkEvent(ev_kind_t k, int v);
        ev_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL event %s: got unexpected value=%0h after sample %0h, required none",
                     k.name(), v, resp_sample);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.value != v || e.at_sample != int'(resp_sample)) begin
                tests_failed++;
                $display("[TB] FAIL event: got %s value=%0h after sample %0h, required %s value=%0h after sample %0h",
                         k.name(), v, resp_sample, e.kind.name(), e.value, e.at_sample);
            end
        end
    endfunction

    // Events in one cycle are checked in a fixed order: wrap, period, step, err.
    always @(negedge clk) begin
        if (wrap_pulse)   checkEvent(EV_WRAP, 0);
        if (period_valid) checkEvent(EV_PERIOD, int'(period_out));
        if (step_valid)   checkEvent(EV_STEP, int'(step_out));
        if (err_pulse)    checkEvent(EV_ERR, 0);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " step_out"},     int'(step_out),     0);
        checkOutput({tag, " step_valid"},   int'(step_valid),   0);
        checkOutput({tag, " locked"},       int'(locked),       0);
        checkOutput({tag, " period_out"},   int'(period_out),   0);
        checkOutput({tag, " period_valid"}, int'(period_valid), 0);
        checkOutput({tag, " wrap_pulse"},   int'(wrap_pulse),   0);
        checkOutput({tag, " err_pulse"},    int'(err_pulse),    0);
    endtask

    task automatic applyStimulus(input logic [W-1:0] s);
        if (use_gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        sample_valid = 1'b1;
        sample       = s;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        resp_sample  = s;
    endtask

    task automatic applyRamp(input logic [W-1:0] start, input logic [W-1:0] step, input int n);
        logic [W-1:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            applyStimulus(v);
            v = v + step;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkQueueEmpty(input string name);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: %0d expected events never appeared, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic stepTwelveRamp();
        expectEvent(EV_STEP,   'h3000, 'hC000);
        expectEvent(EV_WRAP,   0,      'h2000);
        expectEvent(EV_WRAP,   0,      'h1000);
        expectEvent(EV_PERIOD, 5,      'h1000);
        expectEvent(EV_WRAP,   0,      'h0000);
        expectEvent(EV_PERIOD, 5,      'h0000);
        expectEvent(EV_WRAP,   0,      'h2000);
        expectEvent(EV_PERIOD, 6,      'h2000);
        applyRamp(16'h0000, 16'h3000, 23);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        #1;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] continuous ramp, step 0x0100");
        expectEvent(EV_STEP,   'h0100, 'h0400);
        expectEvent(EV_WRAP,   0,      'h0000);
        expectEvent(EV_WRAP,   0,      'h0000);
        expectEvent(EV_PERIOD, 256,    'h0000);
        applyRamp(16'h0000, 16'h0100, 513);
        checkOutput("ramp locked",     int'(locked),         1);
        checkOutput("ramp step_out",   int'(step_out),       'h0100);
        checkOutput("ramp period_out", int'(period_out),     256);
        checkOutput("sat period_out",  int'(sat_period_out), 15);
        checkQueueEmpty("ramp events");

        $display("[TB] reset while locked");
        reset = 1'b1;
        #1;
        checkAllZero("async reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] non-integer period, step 0x3000");
        stepTwelveRamp();
        checkOutput("p3000 locked", int'(locked), 1);
        checkQueueEmpty("p3000 events");

        $display("[TB] same stream with gaps");
        doReset();
        use_gaps = 1'b1;
        stepTwelveRamp();
        checkQueueEmpty("gap events");

        reset = 1'b1;
        #1;
        checkAllZero("gap reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        expectEvent(EV_WRAP,   0, 'h1000);
        expectEvent(EV_WRAP,   0, 'h0000);
        expectEvent(EV_PERIOD, 2, 'h0000);
        applyStimulus(16'hF000);
        applyStimulus(16'h1000);
        applyStimulus(16'h8000);
        applyStimulus(16'h0000);
        checkQueueEmpty("first wrap after reset");
        use_gaps = 1'b0;

        $display("[TB] step change while locked");
        doReset();
        expectEvent(EV_STEP, 'h0100, 'h0400);
        expectEvent(EV_ERR,  0,      'h0900);
        expectEvent(EV_STEP, 'h0200, 'h0F00);
        applyRamp(16'h0000, 16'h0100, 8);
        applyStimulus(16'h0900);
        checkOutput("change locked after err", int'(locked), 0);
        applyRamp(16'h0B00, 16'h0200, 3);
        checkOutput("change relocked",  int'(locked),   1);
        checkOutput("change step_out",  int'(step_out), 'h0200);
        checkQueueEmpty("change events");

        $display("[TB] tolerance");
        doReset();
        expectEvent(EV_STEP, 'h0100, 'h1400);
        expectEvent(EV_ERR,  0,      'h1601);
        applyStimulus(16'h1000);
        applyStimulus(16'h1100);
        applyStimulus(16'h1201);
        applyStimulus(16'h1300);
        applyStimulus(16'h1400);
        checkOutput("tol locked", int'(locked), 1);
        applyStimulus(16'h14FF);
        checkOutput("tol still locked", int'(locked), 1);
        applyStimulus(16'h1601);
        checkOutput("tol unlocked",   int'(locked),   0);
        checkOutput("tol step holds", int'(step_out), 'h0100);
        checkQueueEmpty("tol events");

        $display("[TB] zero step");
        doReset();
        expectEvent(EV_STEP, 0, 'h1234);
        for (int i = 0; i < 8; i++) applyStimulus(16'h1234);
        checkOutput("zero locked",   int'(locked),   1);
        checkOutput("zero step_out", int'(step_out), 0);
        checkQueueEmpty("zero events");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
